spi_ram_burst: RTL and testbench

Parametrised successor to the SPI-slave RAM. It decodes 2-bit command plus data words from the SPI receive path into write-address, write-data, read-address and read operations on an internal memory. It adds per-command address auto-increment with wrap-around and a ready/valid handshake on both the receive and transmit sides. It also flags out-of-range address loads. It sits between the SPI slave shift logic and the SPI transmit shifter.

---
 rtl/spi_ram_pkg.sv | 22 ++
 rtl/spi_ram_burst_if.sv | 22 ++
 rtl/spi_ram_mem.sv | 26 ++
 rtl/spi_ram_burst.sv | 123 ++++++++++++
 tb/tb_spi_ram_burst.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_ram_pkg.sv
// Shared command encodings, FSM state type and address-wrap helper for the
// burst-capable SPI RAM.
package spi_ram_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        TX   = 2'd2
    } state_t;

    // Next address with wrap at depth-1; works for non-power-of-two depths.
    function automatic int unsigned addr_inc(input int unsigned addr,
                                             input int unsigned depth);
        return (addr + 1 >= depth) ? 0 : addr + 1;
    endfunction

endpackage

// File: rtl/spi_ram_burst_if.sv
// Receive/transmit handshake bundle between the SPI shifters and the RAM.
interface spi_ram_burst_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH+1:0] din;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [DATA_WIDTH-1:0] dout;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  addr_err;

    modport master (
        output din, rx_valid, tx_ready,
        input  rx_ready, dout, tx_valid, addr_err
    );

    modport slave (
        input  din, rx_valid, tx_ready,
        output rx_ready, dout, tx_valid, addr_err
    );
endinterface

// File: rtl/spi_ram_mem.sv
// Simple dual-address RAM: one write port, one registered read port.
module spi_ram_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_SIZE  = 8,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_SIZE-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  re,
    input  logic [ADDR_SIZE-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // No reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        if (re) begin
            rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/spi_ram_burst.sv
// Command decoder, address registers and rx/tx handshake FSM around the RAM.
module spi_ram_burst
    import spi_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_SIZE  = 8,
    parameter int MEM_DEPTH  = 256,
    parameter bit AUTO_INC   = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    spi_ram_burst_if.slave  bus
);
    state_t                state_reg;
    logic                  rd_wait_reg;
    logic                  rx_ready_reg;
    logic                  tx_valid_reg;
    logic [DATA_WIDTH-1:0] dout_reg;
    logic                  addr_err_reg;
    logic [ADDR_SIZE-1:0]  wr_addr_reg;
    logic [ADDR_SIZE-1:0]  rd_addr_reg;
    logic [ADDR_SIZE-1:0]  rd_ptr_reg;

    logic [1:0]            cmd;
    logic [DATA_WIDTH-1:0] payload;
    logic                  accept;
    logic                  in_range;
    logic                  mem_we;
    logic                  mem_re;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    assign cmd      = bus.din[DATA_WIDTH+1:DATA_WIDTH];
    assign payload  = bus.din[DATA_WIDTH-1:0];
    assign accept   = bus.rx_valid && rx_ready_reg;
    assign in_range = int'(payload) < MEM_DEPTH;
    assign mem_we   = accept && (cmd == CMD_WR_DATA);
    assign mem_re   = (state_reg == RD) && !rd_wait_reg;

    spi_ram_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_SIZE  (ADDR_SIZE),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_mem (
        .clk     (clk),
        .we      (mem_we),
        .wr_addr (wr_addr_reg),
        .wr_data (payload),
        .re      (mem_re),
        .rd_addr (rd_ptr_reg),
        .rd_data (mem_rd_data)
    );

    // RD spans two cycles: RAM read, then the RAM output is copied into the
    // resettable dout register together with tx_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            rd_wait_reg  <= 1'b0;
            rx_ready_reg <= 1'b1;
            tx_valid_reg <= 1'b0;
            dout_reg     <= '0;
            addr_err_reg <= 1'b0;
            wr_addr_reg  <= '0;
            rd_addr_reg  <= '0;
            rd_ptr_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        case (cmd)
                            CMD_WR_ADDR: begin
                                if (in_range) wr_addr_reg <= payload[ADDR_SIZE-1:0];
                                else          addr_err_reg <= 1'b1;
                            end
                            CMD_WR_DATA: begin
                                if (AUTO_INC)
                                    wr_addr_reg <= ADDR_SIZE'(addr_inc(32'(wr_addr_reg), MEM_DEPTH));
                            end
                            CMD_RD_ADDR: begin
                                if (in_range) rd_addr_reg <= payload[ADDR_SIZE-1:0];
                                else          addr_err_reg <= 1'b1;
                            end
                            default: begin
                                rd_ptr_reg   <= rd_addr_reg;
                                rd_wait_reg  <= 1'b0;
                                rx_ready_reg <= 1'b0;
                                state_reg    <= RD;
                                if (AUTO_INC)
                                    rd_addr_reg <= ADDR_SIZE'(addr_inc(32'(rd_addr_reg), MEM_DEPTH));
                            end
                        endcase
                    end
                end
                RD: begin
                    if (!rd_wait_reg) begin
                        rd_wait_reg <= 1'b1;
                    end else begin
                        dout_reg     <= mem_rd_data;
                        tx_valid_reg <= 1'b1;
                        state_reg    <= TX;
                    end
                end
                TX: begin
                    if (bus.tx_ready) begin
                        tx_valid_reg <= 1'b0;
                        rx_ready_reg <= 1'b1;
                        state_reg    <= IDLE;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    rx_ready_reg <= 1'b1;
                    tx_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_ready = rx_ready_reg;
    assign bus.tx_valid = tx_valid_reg;
    assign bus.dout     = dout_reg;
    assign bus.addr_err = addr_err_reg;
endmodule

// File: tb/tb_spi_ram_burst.sv
// Three spi_ram_burst configurations driven in lockstep and checked against a
// per-instance behavioural model (depth 256, depth 200, no auto-increment).
module tb_spi_ram_burst;
    import spi_ram_pkg::*;

    localparam int NDUT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] din;
    logic       rx_valid;
    logic       tx_ready;

    logic       rdy_w [NDUT];
    logic       txv_w [NDUT];
    logic       err_w [NDUT];
    logic [7:0] dout_w[NDUT];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NDUT; gi++) begin : g_dut
            localparam int DEPTH = (gi == 1) ? 200 : 256;
            localparam bit INC   = (gi != 2);
            spi_ram_burst_if #(.DATA_WIDTH(8)) bus ();
            assign bus.din      = din;
            assign bus.rx_valid = rx_valid;
            assign bus.tx_ready = tx_ready;
            assign rdy_w[gi]    = bus.rx_ready;
            assign txv_w[gi]    = bus.tx_valid;
            assign err_w[gi]    = bus.addr_err;
            assign dout_w[gi]   = bus.dout;
            spi_ram_burst #(
                .DATA_WIDTH (8),
                .ADDR_SIZE  (8),
                .MEM_DEPTH  (DEPTH),
                .AUTO_INC   (INC)
            ) dut (
                .clk (clk),
                .rst (rst),
                .bus (bus.slave)
            );
        end
    endgenerate

    // Reference model state
    logic [7:0] m_mem [NDUT][256];
    bit         m_ok  [NDUT][256];
    int         m_wa  [NDUT];
    int         m_ra  [NDUT];
    bit         m_err [NDUT];
    logic [7:0] m_dout[NDUT];
    bit         m_dok [NDUT];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int depth_of(input int k);
        return (k == 1) ? 200 : 256;
    endfunction

    function automatic bit inc_of(input int k);
        return k != 2;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < NDUT; k++) begin
            m_wa[k] = 0; m_ra[k] = 0; m_err[k] = 0;
            m_dout[k] = 8'h00; m_dok[k] = 1;
        end
    endfunction

    function automatic void model_cmd(input logic [1:0] cmd, input logic [7:0] pl);
        int cap;
        for (int k = 0; k < NDUT; k++) begin
            case (cmd)
                2'b00: if (int'(pl) < depth_of(k)) m_wa[k] = int'(pl); else m_err[k] = 1;
                2'b01: begin
                    m_mem[k][m_wa[k]] = pl;
                    m_ok[k][m_wa[k]]  = 1;
                    if (inc_of(k)) m_wa[k] = (m_wa[k] + 1) % depth_of(k);
                end
                2'b10: if (int'(pl) < depth_of(k)) m_ra[k] = int'(pl); else m_err[k] = 1;
                default: begin
                    cap = m_ra[k];
                    if (inc_of(k)) m_ra[k] = (m_ra[k] + 1) % depth_of(k);
                    m_dok[k]  = m_ok[k][cap];
                    m_dout[k] = m_mem[k][cap];
                end
            endcase
        end
    endfunction

    task automatic check_dout(input string tag);
        for (int k = 0; k < NDUT; k++)
            if (m_dok[k]) chk($sformatf("d%0d %s dout", k, tag), 32'(dout_w[k]), 32'(m_dout[k]));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("d%0d reset rx_ready", k), 32'(rdy_w[k]), 32'd1);
            chk($sformatf("d%0d reset tx_valid", k), 32'(txv_w[k]), 32'd0);
            chk($sformatf("d%0d reset addr_err", k), 32'(err_w[k]), 32'd0);
        end
        check_dout("reset");
    endtask

    // Present one command, wait (bounded) for acceptance, update the model.
    task automatic send(input logic [1:0] cmd, input logic [7:0] pl);
        int n = 0;
        @(negedge clk);
        din = {cmd, pl};
        rx_valid = 1'b1;
        while (!rdy_w[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            chk("accept timeout", 32'd0, 32'd1);
            rx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_cmd(cmd, pl);
        #1;
        rx_valid = 1'b0;
        for (int k = 0; k < NDUT; k++)
            chk($sformatf("d%0d addr_err", k), 32'(err_w[k]), 32'(m_err[k]));
    endtask

    // RD_DATA with optional tx backpressure and a WR_DATA held during it.
    task automatic rd(input int hold, input bit bp, input logic [7:0] bp_pl);
        tx_ready = (hold == 0);
        send(CMD_RD_DATA, 8'($urandom));
        if (bp) begin
            din = {CMD_WR_DATA, bp_pl};
            rx_valid = 1'b1;
        end
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("d%0d lat1 tx_valid", k), 32'(txv_w[k]), 32'd0);
            chk($sformatf("d%0d busy rx_ready", k), 32'(rdy_w[k]), 32'd0);
        end
        @(negedge clk);
        for (int k = 0; k < NDUT; k++)
            chk($sformatf("d%0d lat2 tx_valid", k), 32'(txv_w[k]), 32'd0);
        @(negedge clk);
        for (int k = 0; k < NDUT; k++)
            chk($sformatf("d%0d tx_valid", k), 32'(txv_w[k]), 32'd1);
        check_dout("read");
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            for (int k = 0; k < NDUT; k++) begin
                chk($sformatf("d%0d hold tx_valid", k), 32'(txv_w[k]), 32'd1);
                chk($sformatf("d%0d hold rx_ready", k), 32'(rdy_w[k]), 32'd0);
            end
            check_dout("hold");
        end
        tx_ready = 1'b1;
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("d%0d done tx_valid", k), 32'(txv_w[k]), 32'd0);
            chk($sformatf("d%0d done rx_ready", k), 32'(rdy_w[k]), 32'd1);
        end
        check_dout("after");
        if (bp) begin
            @(posedge clk);
            model_cmd(CMD_WR_DATA, bp_pl);
            #1;
            rx_valid = 1'b0;
        end
    endtask

    task automatic reset_mid_read();
        tx_ready = 1'b1;
        send(CMD_RD_DATA, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("d%0d rst tx_valid", k), 32'(txv_w[k]), 32'd0);
            chk($sformatf("d%0d rst rx_ready", k), 32'(rdy_w[k]), 32'd1);
            chk($sformatf("d%0d rst addr_err", k), 32'(err_w[k]), 32'd0);
        end
        check_dout("rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            for (int k = 0; k < NDUT; k++)
                chk($sformatf("d%0d post-rst tx_valid", k), 32'(txv_w[k]), 32'd0);
        end
    endtask

    initial begin : main
        int         c;
        logic [7:0] pl;
        rst = 1'b1; din = '0; rx_valid = 1'b0; tx_ready = 1'b0;
        do_reset();

        // write then read
        send(CMD_WR_ADDR, 8'h10); send(CMD_WR_DATA, 8'hA5);
        send(CMD_RD_ADDR, 8'h10); rd(0, 1'b0, 8'h00);

        // burst across the top of memory
        send(CMD_WR_ADDR, 8'hFE);
        send(CMD_WR_DATA, 8'h11); send(CMD_WR_DATA, 8'h22); send(CMD_WR_DATA, 8'h33);
        send(CMD_RD_ADDR, 8'hFE);
        rd(0, 1'b0, 8'h00); rd(0, 1'b0, 8'h00); rd(0, 1'b0, 8'h00);

        // wrap at a non-power-of-two depth
        send(CMD_WR_ADDR, 8'd199); send(CMD_WR_DATA, 8'h44); send(CMD_WR_DATA, 8'h55);
        send(CMD_RD_ADDR, 8'd199); rd(1, 1'b0, 8'h00); rd(2, 1'b0, 8'h00);

        // backpressure with a pending write
        send(CMD_RD_ADDR, 8'h10); rd(5, 1'b1, 8'h66);
        send(CMD_RD_ADDR, 8'd201); rd(0, 1'b0, 8'h00);

        // out-of-range loads
        send(CMD_WR_ADDR, 8'hC8); send(CMD_WR_ADDR, 8'h05);
        send(CMD_RD_ADDR, 8'hD0);

        reset_mid_read();
        send(CMD_RD_ADDR, 8'h10); rd(0, 1'b0, 8'h00);

        // repeated writes to one address
        send(CMD_WR_ADDR, 8'h03); send(CMD_WR_DATA, 8'h01); send(CMD_WR_DATA, 8'h02);
        send(CMD_RD_ADDR, 8'h03); rd(0, 1'b0, 8'h00); rd(0, 1'b0, 8'h00);

        for (int i = 0; i < 250; i++) begin
            c  = int'($urandom_range(0, 3));
            pl = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(190, 255))
                                             : 8'($urandom_range(0, 15));
            if (c == 3)
                rd(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom));
            else if (c == 1)
                send(CMD_WR_DATA, 8'($urandom));
            else
                send(2'(c), pl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
